muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core. It executes mult, multu, div and divu over 32 iteration cycles on a shared shift/add-subtract datapath, and owns the HI/LO register pair. It drives a stall request to the hazard logic while a result is pending and the pipeline needs HI/LO or the unit itself.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer for the EX stage.
// Runs mult/multu/div/divu over 32 iteration cycles on one shared
// shift/add-subtract accumulator and owns the architectural HI/LO pair.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op         launch (sampled only in IDLE); 00 mult 01 multu 10 div 11 divu
//   rs_val, rt_val    multiplicand/dividend, multiplier/divisor
//   flush             abort the in-flight operation (HI/LO untouched)
//   hi_we, lo_we      mthi/mtlo write enables (IDLE only), data on wdata
//   hilo_read         mfhi/mflo or a new mult/div is in ID
//   hi, lo            architectural HI/LO
//   busy              operation in flight (state != IDLE)
//   done              one-cycle pulse in the cycle HI/LO hold a new result
//   stall             busy & (hilo_read | start), purely combinational
//   state_dbg         current FSM state (IDLE=0, RUN=1, FIX=2)
//
// Handshake: start is a level sampled on a rising edge only while busy=0;
// while busy=1 start is ignored and stall holds the pipeline instead.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [1:0]       state_dbg
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // acc: multiply -> {spare bit, partial product high, multiplier remaining}
  //      divide   -> {WIDTH+1 bit partial remainder, dividend/quotient bits}
  logic [2*W:0]  acc;
  logic [W-1:0]  mcand;    // multiplicand or divisor magnitude
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          neg_p;    // negate product / quotient
  logic          neg_r;    // negate remainder
  logic          dz;       // divide by zero flagged at capture

  logic launch, step, finish, mt_ok;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    mt_ok     = 1'b0;
    case (state)
      S_IDLE: begin
        // flush in IDLE discards a coincident start; start drops a coincident mthi/mtlo
        if (start && !flush) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
        mt_ok = !start;
      end
      S_RUN: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
        finish    = !flush;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign stall     = busy & (hilo_read | start);
  assign state_dbg = state;

  // ---------------- operand capture ----------------
  logic          sgn;
  logic [W-1:0]  rs_abs, rt_abs;

  always_comb begin
    sgn    = !op[0];
    rs_abs = (sgn && rs_val[W-1]) ? (~rs_val + 1'b1) : rs_val;
    rt_abs = (sgn && rt_val[W-1]) ? (~rt_val + 1'b1) : rt_val;
  end

  // ---------------- iteration datapath ----------------
  logic [W:0]     mul_sum;
  logic [2*W:0]   mul_nxt;
  logic [W+1:0]   div_diff;
  logic [2*W:0]   div_nxt;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit (LSB) is set, then shift the whole accumulator right.
    mul_sum = acc[0] ? ({1'b0, acc[2*W-1:W]} + {1'b0, mcand}) : {1'b0, acc[2*W-1:W]};
    mul_nxt = {1'b0, mul_sum, acc[W-1:1]};
    // Divide: trial-subtract the divisor from the left-shifted remainder;
    // keep the difference and shift in a 1 only if it did not go negative.
    div_diff = acc[2*W:W-1] - {2'b00, mcand};
    div_nxt  = div_diff[W+1] ? {acc[2*W-1:0], 1'b0}
                             : {div_diff[W:0], acc[W-2:0], 1'b1};
  end

  // ---------------- sign fix ----------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_p ? (~acc[2*W-1:0] + 1'b1) : acc[2*W-1:0];
    quot_fix = neg_p ? (~acc[W-1:0] + 1'b1)   : acc[W-1:0];
    rem_fix  = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        is_div <= op[1];
        neg_p  <= sgn & (rs_val[W-1] ^ rt_val[W-1]);
        neg_r  <= sgn & rs_val[W-1];
        dz     <= op[1] && (rt_val == '0);
        cnt    <= CW'(W - 1);
        if (op[1]) begin
          acc <= {{(W+1){1'b0}}, rs_abs};
          // With a zero divisor the iterations are don't-care, so mcand
          // is reused to carry the raw dividend through to HI.
          mcand <= (rt_val == '0) ? rs_val : rt_abs;
        end else begin
          acc   <= {{(W+1){1'b0}}, rt_abs};
          mcand <= rs_abs;
        end
      end else if (step) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        acc <= is_div ? div_nxt : mul_nxt;
      end

      if (finish) begin
        if (!is_div) begin
          {hi, lo} <= prod_fix;
        end else if (dz) begin
          lo <= '1;
          hi <= mcand;
        end else begin
          lo <= quot_fix;
          hi <= rem_fix;
        end
      end else if (mt_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and randomized operations checked
// against an arithmetic reference model, plus flush/reset, stall,
// mthi/mtlo interaction and back-to-back issue.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs_val, rt_val;
  logic          flush;
  logic          hi_we, lo_we;
  logic [W-1:0]  wdata;
  logic          hilo_read;
  logic [W-1:0]  hi, lo;
  logic          busy, done, stall;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ehi = '0;
    elo = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          elo = 32'hFFFF_FFFF;
          ehi = a;
        end else if (o == 2'b11) begin
          elo = a / b;
          ehi = a % b;
        end else begin
          // 64-bit arithmetic: 0x80000000 / -1 gives +2^31, which wraps to 0x80000000
          q = sa / sb;
          r = sa % sb;
          elo = q[31:0];
          ehi = r[31:0];
        end
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Launches one operation and observes 35 cycles; sample k is taken just
  // after the falling edge that follows edge E(k).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hr,
                       output logic [31:0] ghi, output logic [31:0] glo,
                       output int busy_n, output int done_n, output int done_at,
                       output int stall_n);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; hilo_read = hr;
    busy_n = 0; done_n = 0; done_at = -1; stall_n = 0;
    ghi = hi; glo = lo;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      #1;
      if (busy)  busy_n++;
      if (stall) stall_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          ghi = hi;
          glo = lo;
        end
      end
    end
    hilo_read = 1'b0;
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clk);
    hi_we = whi; lo_we = wlo; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    start = 0; op = 0; rs_val = 0; rt_val = 0; flush = 0;
    hi_we = 0; lo_we = 0; wdata = 0; hilo_read = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (hi !== 32'h0)     begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0)     begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || hi !== 32'h0) begin n_fail++; $display("FAIL post_reset_idle: busy %b hi %h expected 0/0", busy, hi); end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'd7, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9};
    logic [31:0] t_b  [8] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2,
                              32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ghi, glo, ehi, elo;
    int bn, dn, da, sn;
    for (int i = 0; i < 8; i++) begin
      model(t_op[i], t_a[i], t_b[i], ehi, elo);
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, ghi, glo, bn, dn, da, sn);
      n_checks++; if (ghi !== ehi) begin n_fail++; $display("FAIL dir%0d_hi: got %h expected %h", i, ghi, ehi); end
      n_checks++; if (glo !== elo) begin n_fail++; $display("FAIL dir%0d_lo: got %h expected %h", i, glo, elo); end
      n_checks++; if (da !== 33)   begin n_fail++; $display("FAIL dir%0d_done_cycle: got %0d expected 33", i, da); end
      n_checks++; if (dn !== 1)    begin n_fail++; $display("FAIL dir%0d_done_width: got %0d expected 1", i, dn); end
      n_checks++; if (bn !== 33)   begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bn); end
    end
  endtask

  function automatic logic [31:0] pick_operand;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] a, b, ghi, glo, ehi, elo;
    logic [1:0]  o;
    int bn, dn, da, sn;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      model(o, a, b, ehi, elo);
      do_op(o, a, b, 1'b0, ghi, glo, bn, dn, da, sn);
      n_checks++;
      if (ghi !== ehi || glo !== elo || da !== 33) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got hi=%h lo=%h at %0d expected hi=%h lo=%h at 33",
                 i, o, a, b, ghi, glo, da, ehi, elo);
      end
    end
  endtask

  task automatic test_flush_reset;
    int dn;
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    #1;
    n_checks++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL mthi_mtlo: got %h/%h expected 11/22", hi, lo); end
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 9) flush = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    @(negedge clk);
    flush = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) dn++;
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dn); end
    n_checks++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL flush_hilo: got %h/%h expected 11/22", hi, lo); end

    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL midrun_reset_hilo: got %h/%h expected 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_stall_mthi;
    logic [31:0] ghi, glo, ehi, elo, hi0;
    int bn, dn, da, sn;
    logic seen;
    do_op(2'b11, 32'd1000, 32'd7, 1'b1, ghi, glo, bn, dn, da, sn);
    n_checks++; if (sn !== 33) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 33", sn); end
    n_checks++; if (ghi !== 32'd6 || glo !== 32'd142) begin n_fail++; $display("FAIL stall_op_result: got %h/%h expected 6/142", ghi, glo); end
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %b expected 0", stall); end

    // mthi/mtlo while busy must be ignored
    model(2'b01, 32'd3, 32'd4, ehi, elo);
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL busy_mt_done: got %b expected 1", seen); end
    n_checks++; if (hi !== ehi || lo !== elo) begin n_fail++; $display("FAIL busy_mt_ignored: got %h/%h expected %h/%h", hi, lo, ehi, elo); end

    // start together with mthi in IDLE: the write is dropped
    hi0 = hi;
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_val = 32'd7; rt_val = 32'd2; hi_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    #1;
    n_checks++; if (hi !== hi0) begin n_fail++; $display("FAIL start_mthi_drop: got %h expected %h", hi, hi0); end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_checks++; if (!seen || hi !== 32'd1 || lo !== 32'd3) begin n_fail++; $display("FAIL start_mthi_result: got %h/%h done %b expected 1/3 done 1", hi, lo, seen); end

    // plain mthi in IDLE still works
    mt_write(1'b1, 1'b0, 32'h77);
    #1;
    n_checks++; if (hi !== 32'h77 || lo !== 32'd3) begin n_fail++; $display("FAIL idle_mthi: got %h/%h expected 77/3", hi, lo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e1hi, e1lo, e2hi, e2lo;
    logic [31:0] d_hi [$];
    logic [31:0] d_lo [$];
    int d_at [$];
    model(2'b00, 32'hFFFF_FFF0, 32'd12345, e1hi, e1lo);
    model(2'b10, 32'd1000001, 32'hFFFF_FFF3, e2hi, e2lo);
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_FFF0; rt_val = 32'd12345;
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      if (k == 0)  start = 1'b0;
      if (k == 10) begin start = 1'b1; op = 2'b11; rs_val = 32'd5; rt_val = 32'd1; end
      if (k == 11) start = 1'b0;
      if (k == 34) start = 1'b0;
      #1;
      if (done) begin d_at.push_back(k); d_hi.push_back(hi); d_lo.push_back(lo); end
      if (k == 33) begin start = 1'b1; op = 2'b10; rs_val = 32'd1000001; rt_val = 32'hFFFF_FFF3; end
      if (k == 34) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
      end
    end
    n_checks++;
    if (d_at.size() !== 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", d_at.size());
    end else begin
      n_checks++; if (d_at[0] !== 33 || d_hi[0] !== e1hi || d_lo[0] !== e1lo) begin n_fail++;
        $display("FAIL b2b_first: got %h/%h at %0d expected %h/%h at 33", d_hi[0], d_lo[0], d_at[0], e1hi, e1lo); end
      n_checks++; if (d_at[1] !== 67 || d_hi[1] !== e2hi || d_lo[1] !== e2lo) begin n_fail++;
        $display("FAIL b2b_second: got %h/%h at %0d expected %h/%h at 67", d_hi[1], d_lo[1], d_at[1], e2hi, e2lo); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush_reset();
    test_stall_mthi();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
